matmul_read_sequencer: RTL and testbench

- Controller that sequences the dual-port matrix operand RAM for an OUTER_DIMENSION×INNER_DIMENSION by INNER_DIMENSION×OUTER_DIMENSION multiply.
- Generates the counter_A/counter_B read addresses, plus a valid/tag stream aligned to the RAM's 1-cycle registered read data.
- Sits between the top-level control (start/done) and the RAM plus the downstream chunk multiply-accumulate unit. Supports backpressure from the accumulator.

---
 rtl/matmul_read_sequencer.sv | 161 ++++++++++++++++
 tb/tb_matmul_read_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_read_sequencer.sv
// rtl/matmul_read_sequencer.sv - read address / valid-tag sequencer for the matmul operand RAM
module matmul_read_sequencer #(
    parameter int WIDTH           = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int INNER_DIMENSION = 4,
    parameter int OUTER_DIMENSION = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_ready,
    output logic [WIDTH-1:0] counter_A,
    output logic [WIDTH-1:0] counter_B,
    output logic             busy,
    output logic             rd_valid,
    output logic             rd_first,
    output logic             rd_last,
    output logic [WIDTH-1:0] out_row,
    output logic [WIDTH-1:0] out_col,
    output logic             done
);

    localparam int NCHUNK = INNER_DIMENSION / CHUNK_SIZE;
    localparam logic [WIDTH-1:0] NCHUNK_W = WIDTH'(NCHUNK);
    localparam logic [WIDTH-1:0] K_MAX    = WIDTH'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] O_MAX    = WIDTH'(OUTER_DIMENSION - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // The inner dimension has to split into whole RAM words.
    generate
        if ((INNER_DIMENSION % CHUNK_SIZE) != 0 || NCHUNK < 1) begin : g_bad_dims
            $error("INNER_DIMENSION must be a non-zero multiple of CHUNK_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] counter_a_q, counter_a_d, counter_b_q, counter_b_d;
    logic [WIDTH-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic             busy_q, busy_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_first_q, rd_first_d;
    logic             rd_last_q, rd_last_d;
    logic             done_q, done_d;

    logic issue, last_k, last_j, last_i, final_issue;

    // Next-state: loop counters (k innermost, then j, then i) and the tags of this cycle's issue.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;

        issue       = (state_q == S_RUN) && acc_ready;
        last_k      = (k_q == K_MAX);
        last_j      = (j_q == O_MAX);
        last_i      = (i_q == O_MAX);
        final_issue = issue && last_k && last_j && last_i;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (final_issue) begin
                        state_d = S_DRAIN;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end else if (last_k) begin
                        k_d = '0;
                        if (last_j) begin
                            j_d = '0;
                            i_d = i_q + ONE;
                        end else begin
                            j_d = j_q + ONE;
                        end
                    end else begin
                        k_d = k_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
            end
        endcase

        // Addresses are registered copies of the next loop position.
        counter_a_d = i_d * NCHUNK_W + k_d;
        counter_b_d = j_d * NCHUNK_W + k_d;

        // Beat tags ride one cycle behind the issue to line up with the RAM's registered read.
        rd_valid_d = issue;
        rd_first_d = issue && (k_q == '0);
        rd_last_d  = issue && last_k;
        out_row_d  = issue ? i_q : '0;
        out_col_d  = issue ? j_q : '0;
        done_d     = final_issue;
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            counter_a_q <= '0;
            counter_b_q <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            counter_a_q <= counter_a_d;
            counter_b_q <= counter_b_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_first_q  <= rd_first_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    assign counter_A = counter_a_q;
    assign counter_B = counter_b_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_first  = rd_first_q;
    assign rd_last   = rd_last_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matmul_read_sequencer.sv
// tb/tb_matmul_read_sequencer.sv - directed self-checking bench for matmul_read_sequencer
module tb_matmul_read_sequencer;

    localparam int W   = 16;
    localparam int OUT = 6;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, acc_ready;

    logic [W-1:0] ca_a, cb_a, row_a, col_a, ca_b, cb_b, row_b, col_b;
    logic         busy_a, v_a, f_a, l_a, done_a;
    logic         busy_b, v_b, f_b, l_b, done_b;

    logic [W-1:0] o_ca, o_cb, o_row, o_col;
    logic         o_busy, o_v, o_f, o_l, o_done;
    int           sel;

    int checks   = 0;
    int failures = 0;
    int dcyc;

    always #5 clk = ~clk;

    matmul_read_sequencer u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .acc_ready(acc_ready),
        .counter_A(ca_a), .counter_B(cb_a), .busy(busy_a),
        .rd_valid(v_a), .rd_first(f_a), .rd_last(l_a),
        .out_row(row_a), .out_col(col_a), .done(done_a)
    );

    matmul_read_sequencer #(.INNER_DIMENSION(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .acc_ready(acc_ready),
        .counter_A(ca_b), .counter_B(cb_b), .busy(busy_b),
        .rd_valid(v_b), .rd_first(f_b), .rd_last(l_b),
        .out_row(row_b), .out_col(col_b), .done(done_b)
    );

    // Observe whichever instance is under test.
    always_comb begin
        if (sel == 1) begin
            o_ca = ca_b; o_cb = cb_b; o_row = row_b; o_col = col_b;
            o_busy = busy_b; o_v = v_b; o_f = f_b; o_l = l_b; o_done = done_b;
        end else begin
            o_ca = ca_a; o_cb = cb_a; o_row = row_a; o_col = col_a;
            o_busy = busy_a; o_v = v_a; o_f = f_a; o_l = l_a; o_done = done_a;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel == 1) start_b = v;
        else          start_a = v;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_addr_a"}, o_ca, 0);
        check({tag, "_addr_b"}, o_cb, 0);
        check({tag, "_busy"},   o_busy, 0);
        check({tag, "_valid"},  o_v, 0);
        check({tag, "_first"},  o_f, 0);
        check({tag, "_last"},   o_l, 0);
        check({tag, "_row"},    o_row, 0);
        check({tag, "_col"},    o_col, 0);
        check({tag, "_done"},   o_done, 0);
    endtask

    // One full pass with a reference loop model. Called at a point away from the clock edge.
    task automatic run_pass(input int nch, input int stall_at, input int stall_len,
                            input int extra1, input int extra2, input int abort_at,
                            output int done_cyc);
        int   ii = 0, jj = 0, kk = 0, issued = 0, beats = 0, stalls = 0;
        int   cyc = 0, first_cyc = -1, total, pr = 0, pc = 0;
        logic pv = 0, pf = 0, pl = 0, pd = 0, running, acc;
        bit   fin = 0;
        total    = OUT * OUT * nch;
        done_cyc = -1;
        drive_start(1'b1);
        @(posedge clk);
        cyc = 1;
        while (!fin) begin
            @(negedge clk);
            drive_start(cyc == extra1 || cyc == extra2);
            running = (issued < total);
            check("addr_a",   o_ca,   running ? ii * nch + kk : 0);
            check("addr_b",   o_cb,   running ? jj * nch + kk : 0);
            check("rd_valid", o_v,    pv);
            check("rd_first", o_f,    pf);
            check("rd_last",  o_l,    pl);
            check("out_row",  o_row,  pr);
            check("out_col",  o_col,  pc);
            check("done",     o_done, pd);
            check("busy",     o_busy, running || pv);
            if (pv) begin
                beats++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (pd) done_cyc = cyc;
            if (abort_at >= 0 && beats == abort_at) begin
                rst = 1'b1;
                #1;
                check_quiet("async_rst");
                #1;
                rst = 1'b0;
                drive_start(1'b0);
                acc_ready = 1'b1;
                return;
            end
            if (!running && !pv) begin
                fin = 1;
            end else begin
                acc = !(issued == stall_at && stalls < stall_len);
                if (!acc && running) stalls++;
                acc_ready = acc;
                pv = running && acc;
                pf = pv && (kk == 0);
                pl = pv && (kk == nch - 1);
                pr = pv ? ii : 0;
                pc = pv ? jj : 0;
                pd = pv && (issued == total - 1);
                if (pv) begin
                    issued++;
                    if (kk == nch - 1) begin
                        kk = 0;
                        if (jj == OUT - 1) begin
                            jj = 0;
                            ii = ii + 1;
                        end else begin
                            jj = jj + 1;
                        end
                    end else begin
                        kk = kk + 1;
                    end
                end
                @(posedge clk);
                cyc++;
                if (cyc > 400) begin
                    check("cycle_budget", cyc, 400);
                    fin = 1;
                end
            end
        end
        acc_ready = 1'b1;
        check("beat_count", beats, total);
        check("first_valid_cyc", first_cyc, 2);
        check("done_cyc", done_cyc, total + 1 + stalls);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_quiet(tag);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        acc_ready = 1'b1;
        sel       = 0;
        #1;
        check_quiet("reset_a");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2, "idle_a");

        // Plain pass, NCHUNK=1: done at start+37.
        run_pass(1, -1, 0, -1, -1, -1, dcyc);
        check("plain_done_37", dcyc, 37);
        idle_cycles(2, "after_plain");

        // Three stall cycles after beat 4: done at start+40.
        run_pass(1, 4, 3, -1, -1, -1, dcyc);
        check("stall_done_40", dcyc, 40);
        idle_cycles(2, "after_stall");

        // start mid-pass and coincident with done must both be ignored.
        run_pass(1, -1, 0, 10, 37, -1, dcyc);
        idle_cycles(4, "ignored_start");

        // Asynchronous reset at beat 10, then a clean restart from (0,0).
        run_pass(1, -1, 0, -1, -1, 10, dcyc);
        idle_cycles(3, "after_abort");
        run_pass(1, -1, 0, -1, -1, -1, dcyc);
        check("restart_done_37", dcyc, 37);

        // Back-to-back: start the cycle after done.
        run_pass(1, -1, 0, -1, -1, -1, dcyc);
        check("b2b_done_37", dcyc, 37);
        idle_cycles(2, "after_b2b");

        // NCHUNK=2 instance: 72 beats, done at start+73.
        sel = 1;
        idle_cycles(1, "idle_b");
        run_pass(2, -1, 0, -1, -1, -1, dcyc);
        check("nchunk2_done_73", dcyc, 73);
        idle_cycles(2, "after_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
